// File: rtl/serial_frame_tx.sv
// Serial frame transmitter. Each frame is sent as: start bit 0, 2-bit port, 4-bit len, len payload bits, stop bit 1.
// Every output is registered. The line advances one bit on each bit_en strobe; start is sampled only in IDLE.
module serial_frame_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        start,
    input  logic [1:0]  port,
    input  logic [3:0]  len,
    input  logic [14:0] data,
    output logic        ser_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        PORT  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  port_q;
    logic [3:0]  len_q;
    logic [14:0] data_q;
    logic [3:0]  cnt_m1;
    logic [3:0]  len_m1;

    // cnt holds the index of the bit currently on the line, so the next bit is cnt-1
    always_comb begin
        cnt_m1 = cnt - 4'd1;
        len_m1 = len_q - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            port_q  <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= 15'd0;
            ser_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    cnt     <= 4'd0;
                    // bit_en in the acceptance cycle is deliberately ignored
                    if (start) begin
                        port_q  <= port;
                        len_q   <= len;
                        data_q  <= data;
                        state   <= START;
                        ser_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_en) begin
                        state   <= PORT;
                        cnt     <= 4'd1;
                        ser_out <= port_q[1];
                    end
                end
                PORT: begin
                    if (bit_en) begin
                        if (cnt == 4'd0) begin
                            state   <= LEN;
                            cnt     <= 4'd3;
                            ser_out <= len_q[3];
                        end else begin
                            cnt     <= cnt_m1;
                            ser_out <= port_q[cnt_m1[0]];
                        end
                    end
                end
                LEN: begin
                    if (bit_en) begin
                        if (cnt == 4'd0) begin
                            if (len_q != 4'd0) begin
                                state   <= DATA;
                                cnt     <= len_m1;
                                ser_out <= data_q[len_m1];
                            end else begin
                                state   <= STOP;
                                cnt     <= 4'd0;
                                ser_out <= 1'b1;
                            end
                        end else begin
                            cnt     <= cnt_m1;
                            ser_out <= len_q[cnt_m1[1:0]];
                        end
                    end
                end
                DATA: begin
                    if (bit_en) begin
                        if (cnt == 4'd0) begin
                            state   <= STOP;
                            ser_out <= 1'b1;
                        end else begin
                            cnt     <= cnt_m1;
                            ser_out <= data_q[cnt_m1];
                        end
                    end
                end
                STOP: begin
                    if (bit_en) begin
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        ser_out <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 4'd0;
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
